// File: rtl/ready_valid_receiver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ready_valid_receiver_pkg
// Description : Shared state encoding and default widths for the burst receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package ready_valid_receiver_pkg;

    localparam int RV_DATA_W = 32;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_RECV = 2'd1,
        RX_DONE = 2'd2
    } rv_rx_state_t;

endpackage : ready_valid_receiver_pkg
`default_nettype wire

// File: rtl/ready_valid_receiver_if.sv
`default_nettype none
// ============================================================================
// Module      : ready_valid_receiver_if
// Description : Ready/valid beat channel between a burst producer and receiver.
// Revision    : 1.0 - initial release
// ============================================================================
interface ready_valid_receiver_if
    import ready_valid_receiver_pkg::*;
#(
    parameter int DATA_W = RV_DATA_W
) ();

    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready
    );

endinterface : ready_valid_receiver_if
`default_nettype wire

// File: rtl/ready_valid_receiver.sv
`default_nettype none
// ============================================================================
// Module      : ready_valid_receiver
// Description : Armed by go, accepts MAX_VAL+1 beats, tracks last beat and a
//               modular checksum, then pulses done for one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module ready_valid_receiver
    import ready_valid_receiver_pkg::*;
#(
    parameter int WIDTH   = 2,
    parameter int MAX_VAL = 3,
    parameter int DATA_W  = RV_DATA_W
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              go,
    input  wire logic              stall,
    ready_valid_receiver_if.slave  s,
    output logic                   busy,
    output logic [WIDTH-1:0]       beat_cnt,
    output logic [DATA_W-1:0]      last_data,
    output logic [DATA_W-1:0]      checksum,
    output logic                   done
);

    localparam logic [WIDTH-1:0] c_LAST_BEAT = WIDTH'(MAX_VAL);

    if (MAX_VAL >= (1 << WIDTH)) begin : g_param_check
        $error("ready_valid_receiver: MAX_VAL must be below 2**WIDTH");
    end

    rv_rx_state_t      r_state;
    rv_rx_state_t      w_next_state;
    logic [WIDTH-1:0]  r_beat_cnt;
    logic [DATA_W-1:0] r_last_data;
    logic [DATA_W-1:0] r_checksum;
    logic              w_ready;
    logic              w_accept;
    logic              w_final_beat;

    // Ready depends only on registered state and local stall, never on s_valid.
    assign w_ready      = (r_state == RX_RECV) && !stall;
    assign w_accept     = s.s_valid && w_ready;
    assign w_final_beat = (r_beat_cnt == c_LAST_BEAT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RX_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RX_IDLE: begin
                if (go) begin
                    w_next_state = RX_RECV;
                end
            end
            RX_RECV: begin
                if (w_accept && w_final_beat) begin
                    w_next_state = RX_DONE;
                end
            end
            RX_DONE: begin
                w_next_state = RX_IDLE;
            end
            default: begin
                w_next_state = RX_IDLE;
            end
        endcase
    end

    // Counter saturates at the final beat so it reads MAX_VAL throughout DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat_cnt  <= '0;
            r_last_data <= '0;
            r_checksum  <= '0;
        end else begin
            case (r_state)
                RX_IDLE: begin
                    if (go) begin
                        r_beat_cnt <= '0;
                        r_checksum <= '0;
                    end
                end
                RX_RECV: begin
                    if (w_accept) begin
                        r_last_data <= s.s_data;
                        r_checksum  <= r_checksum + s.s_data;
                        if (!w_final_beat) begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_beat_cnt <= r_beat_cnt;
                end
            endcase
        end
    end

    assign s.s_ready = w_ready;
    assign busy      = (r_state != RX_IDLE);
    assign done      = (r_state == RX_DONE);
    assign beat_cnt  = r_beat_cnt;
    assign last_data = r_last_data;
    assign checksum  = r_checksum;

endmodule : ready_valid_receiver
`default_nettype wire

// File: tb/tb_ready_valid_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_ready_valid_receiver
// Description : Directed self-checking bench for the burst receiver, with an
//               8-bit payload twin to exercise checksum wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ready_valid_receiver;

    logic        clk = 1'b0;
    logic        rst;
    logic        go;
    logic        stall;
    logic        busy,  busy8;
    logic        done,  done8;
    logic [1:0]  beat_cnt, beat_cnt8;
    logic [31:0] last_data, checksum;
    logic [7:0]  last_data8, checksum8;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;
    int t0     = 0;

    ready_valid_receiver_if #(.DATA_W(32)) bus  ();
    ready_valid_receiver_if #(.DATA_W(8))  bus8 ();

    assign bus8.s_valid = bus.s_valid;
    assign bus8.s_data  = bus.s_data[7:0];

    ready_valid_receiver #(.WIDTH(2), .MAX_VAL(3), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .go        (go),
        .stall     (stall),
        .s         (bus.slave),
        .busy      (busy),
        .beat_cnt  (beat_cnt),
        .last_data (last_data),
        .checksum  (checksum),
        .done      (done)
    );

    ready_valid_receiver #(.WIDTH(2), .MAX_VAL(3), .DATA_W(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .go        (go),
        .stall     (stall),
        .s         (bus8.slave),
        .busy      (busy8),
        .beat_cnt  (beat_cnt8),
        .last_data (last_data8),
        .checksum  (checksum8),
        .done      (done8)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic arm();
        go = 1'b1;
        tick();
        go = 1'b0;
        t0 = cyc;
    endtask

    // One beat: optional stall cycles first, then the accepting cycle, then an optional gap.
    task automatic beat(input logic [31:0] d, input int stall_n, input bit gap_after);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        for (int i = 0; i < stall_n; i++) begin
            stall = 1'b1;
            #1 chk("ready_low_stalled", {31'd0, bus.s_ready}, 32'd0);
            tick();
        end
        stall = 1'b0;
        #1 chk("ready_high", {31'd0, bus.s_ready}, 32'd1);
        tick();
        if (gap_after) begin
            bus.s_valid = 1'b0;
            tick();
        end
    endtask

    task automatic end_burst(input string tag, input int lat, input logic [31:0] sum,
                             input logic [31:0] last);
        chk({tag, "_done"},    {31'd0, done}, 32'd1);
        chk({tag, "_latency"}, cyc - t0, lat);
        chk({tag, "_sready"},  {31'd0, bus.s_ready}, 32'd0);
        chk({tag, "_busy"},    {31'd0, busy}, 32'd1);
        chk({tag, "_cnt"},     {30'd0, beat_cnt}, 32'd3);
        chk({tag, "_sum"},     checksum, sum);
        chk({tag, "_last"},    last_data, last);
        bus.s_valid = 1'b0;
        tick();
        chk({tag, "_done_off"}, {31'd0, done}, 32'd0);
        chk({tag, "_idle"},     {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; go = 1'b0; stall = 1'b0;
        bus.s_valid = 1'b1; bus.s_data = 32'd5;
        tick(); tick();
        chk("rst_sready", {31'd0, bus.s_ready}, 32'd0);
        chk("rst_cnt",    {30'd0, beat_cnt}, 32'd0);
        chk("rst_sum",    checksum, 32'd0);
        chk("rst_last",   last_data, 32'd0);
        chk("rst_busy",   {31'd0, busy}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("prego_sready", {31'd0, bus.s_ready}, 32'd0);
            chk("prego_done",   {31'd0, done}, 32'd0);
            chk("prego_cnt",    {30'd0, beat_cnt}, 32'd0);
        end
        bus.s_valid = 1'b0;

        // Basic burst
        arm();
        beat(32'd1, 0, 1'b0);
        beat(32'd2, 0, 1'b0);
        beat(32'd3, 0, 1'b0);
        beat(32'd4, 0, 1'b0);
        end_burst("basic", 4, 32'd10, 32'd4);

        // Backpressure on beats 2 and 3
        arm();
        beat(32'd1, 0, 1'b0);
        beat(32'd2, 2, 1'b0);
        beat(32'd3, 2, 1'b0);
        beat(32'd4, 0, 1'b0);
        end_burst("stall", 8, 32'd10, 32'd4);

        // Producer gaps
        arm();
        beat(32'd7, 0, 1'b1);
        beat(32'd7, 0, 1'b1);
        beat(32'd7, 0, 1'b1);
        beat(32'd7, 0, 1'b0);
        end_burst("gaps", 7, 32'd28, 32'd7);

        // go held high: back-to-back bursts every 6 cycles
        go = 1'b1; bus.s_valid = 1'b1; bus.s_data = 32'd1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("hold_done", {31'd0, done}, {31'd0, (k % 6) == 5});
            if (k == 5)  chk("hold_sum_full",  checksum, 32'd4);
            if (k == 7)  chk("hold_sum_rearm", checksum, 32'd0);
            if (k == 8)  chk("hold_cnt_rearm", {30'd0, beat_cnt}, 32'd1);
        end
        go = 1'b0; bus.s_valid = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;

        // Reset mid-burst
        arm();
        beat(32'd9, 0, 1'b0);
        beat(32'd9, 0, 1'b0);
        chk("mid_sum_pre", checksum, 32'd18);
        rst = 1'b1; bus.s_valid = 1'b1; bus.s_data = 32'd100;
        tick();
        rst = 1'b0; bus.s_valid = 1'b0;
        chk("midrst_cnt",    {30'd0, beat_cnt}, 32'd0);
        chk("midrst_sum",    checksum, 32'd0);
        chk("midrst_last",   last_data, 32'd0);
        chk("midrst_done",   {31'd0, done}, 32'd0);
        chk("midrst_sready", {31'd0, bus.s_ready}, 32'd0);
        chk("midrst_busy",   {31'd0, busy}, 32'd0);
        arm();
        beat(32'd1, 0, 1'b0);
        beat(32'd2, 0, 1'b0);
        beat(32'd3, 0, 1'b0);
        beat(32'd4, 0, 1'b0);
        end_burst("postrst", 4, 32'd10, 32'd4);

        // Checksum wrap on the 8-bit twin
        arm();
        beat(32'd200, 0, 1'b0);
        beat(32'd100, 0, 1'b0);
        beat(32'd0, 0, 1'b0);
        beat(32'd0, 0, 1'b0);
        chk("wrap_sum8",   {24'd0, checksum8}, 32'd44);
        chk("wrap_last8",  {24'd0, last_data8}, 32'd0);
        chk("wrap_done8",  {31'd0, done8}, 32'd1);
        chk("wrap_ready8", {31'd0, bus8.s_ready}, 32'd0);
        chk("wrap_busy8",  {31'd0, busy8}, 32'd1);
        chk("wrap_cnt8",   {30'd0, beat_cnt8}, 32'd3);
        end_burst("wrap32", 4, 32'd300, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_ready_valid_receiver
`default_nettype wire
